branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 109 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: static not-taken, bimodal or gshare table of saturating
// counters, with a global history register and resolved/mispredict statistics.

// One saturating counter of the prediction table.
module bp_counter #(
  parameter int              CNT_W   = 2,
  parameter logic [CNT_W-1:0] CNT_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] ctr
);

  // Saturating up/down count; inc and dec are never both high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ctr <= CNT_RST;
    else if (inc && (ctr != '1))     ctr <= ctr + 1'b1;
    else if (dec && (ctr != '0))     ctr <= ctr - 1'b1;
  end

endmodule

module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1,
  parameter int STAT_W  = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_if,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [IDX_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic              mispredict,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  // Weakly-not-taken: all ones below the MSB (0 when CNT_W is 1).
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W-1)) - 1);

  logic [ENTRIES-1:0][CNT_W-1:0] ctr;
  logic [IDX_W-1:0]              ghr;
  logic [IDX_W-1:0]              rd_idx;
  logic [IDX_W-1:0]              wr_idx;
  logic                          tbl_upd;

  // Address bits outside the index field are intentionally ignored.
  wire unused_ok = &{1'b0, pc_if[31:IDX_W+2], pc_if[1:0],
                     upd_pc[31:IDX_W+2], upd_pc[1:0]};

  // Read and write indices; gshare folds history into the PC bits.
  always_comb begin
    rd_idx = pc_if[IDX_W+1:2];
    wr_idx = upd_pc[IDX_W+1:2];
    if (MODE == 2) begin
      rd_idx = pc_if[IDX_W+1:2] ^ ghr;
      wr_idx = upd_pc[IDX_W+1:2] ^ upd_ghr;
    end
  end

  // Static mode never trains the table.
  assign tbl_upd    = upd_valid && (MODE != 0);
  assign pred_taken = (MODE == 0) ? 1'b0 : ctr[rd_idx][CNT_W-1];
  assign pred_ghr   = ghr;

  genvar e;
  generate
    for (e = 0; e < ENTRIES; e++) begin : g_ent
      bp_counter #(.CNT_W(CNT_W), .CNT_RST(CNT_RST)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (tbl_upd && (wr_idx == IDX_W'(e)) &&  upd_taken),
        .dec   (tbl_upd && (wr_idx == IDX_W'(e)) && !upd_taken),
        .ctr   (ctr[e])
      );
    end
  endgenerate

  // Global history: shift in each resolved outcome, gshare only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ghr <= '0;
    else if ((MODE == 2) && upd_valid) ghr <= {ghr[IDX_W-2:0], upd_taken};
  end

  // Registered mispredict pulse and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict <= 1'b0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      mispredict <= upd_valid && (upd_taken != upd_pred);
      if (upd_valid && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (upd_valid && (upd_taken != upd_pred) && (miss_cnt != '1))
        miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule
